gpio_bus_slave: RTL

Memory-mapped register responder for one GPIO port, placed between the MIPS core's data bus and the `gpio_one_port` pin block. Accepts single-cycle write and read strobes from the core, holds the port direction and output registers, and returns sampled pin data. Optionally detects rising and falling edges on sampled inputs and raises a level interrupt to the core.

---
 rtl/gpio_bus_slave.sv | 118 +++++++++++
 1 files changed

// File: rtl/gpio_bus_slave.sv
// rtl/gpio_bus_slave.sv - GPIO register responder between the core data bus and one GPIO port
// Optional edge-detect interrupt block built when GPIO_IRQ_EN is defined.
module gpio_bus_slave #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [2:0]       i_addr,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_rvalid,
    output logic [WIDTH-1:0] o_dir,
    output logic [WIDTH-1:0] o_dout,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_irq
);

    localparam logic [2:0] ADDR_DIR     = 3'd0;
    localparam logic [2:0] ADDR_OUT     = 3'd1;
    localparam logic [2:0] ADDR_IN      = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN = 3'd4;
    localparam logic [2:0] ADDR_STATUS  = 3'd5;

    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] din_q;
    logic [WIDTH-1:0] rd_mux;

    assign o_dir  = dir_q;
    assign o_dout = out_q;

    // Core registers and the input sampling stage
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            dir_q <= '0;
            out_q <= '0;
            din_q <= '0;
        end else begin
            din_q <= i_din;
            if (i_we && i_addr == ADDR_DIR) dir_q <= i_wdata;
            if (i_we && i_addr == ADDR_OUT) out_q <= i_wdata;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] din_prev;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] w1c_mask;

    // Enabled edge events; a new event beats a simultaneous W1C on the same bit
    always_comb begin
        edge_set = (rise_en_q & din_q & ~din_prev) | (fall_en_q & ~din_q & din_prev);
        w1c_mask = (i_we && i_addr == ADDR_STATUS) ? i_wdata : '0;
    end

    // Edge-detect history, enable masks and pending status
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            din_prev  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
        end else begin
            din_prev <= din_q;
            if (i_we && i_addr == ADDR_RISE_EN) rise_en_q <= i_wdata;
            if (i_we && i_addr == ADDR_FALL_EN) fall_en_q <= i_wdata;
            status_q <= (status_q & ~w1c_mask) | edge_set;
        end
    end

    assign o_irq = |status_q;

    // Read data selection from current (pre-write) register values
    always_comb begin
        rd_mux = '0;
        case (i_addr)
            ADDR_DIR:     rd_mux = dir_q;
            ADDR_OUT:     rd_mux = out_q;
            ADDR_IN:      rd_mux = din_q;
            ADDR_RISE_EN: rd_mux = rise_en_q;
            ADDR_FALL_EN: rd_mux = fall_en_q;
            ADDR_STATUS:  rd_mux = status_q;
            default:      rd_mux = '0;
        endcase
    end
`else
    assign o_irq = 1'b0;

    // Read data selection; interrupt addresses read as zero in this build
    always_comb begin
        rd_mux = '0;
        case (i_addr)
            ADDR_DIR: rd_mux = dir_q;
            ADDR_OUT: rd_mux = out_q;
            ADDR_IN:  rd_mux = din_q;
            default:  rd_mux = '0;
        endcase
    end
`endif

    // Registered read response; rdata holds its value between reads
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
        end else begin
            o_rvalid <= i_re;
            if (i_re) o_rdata <= rd_mux;
        end
    end

endmodule
